alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX issue register that produces the 4-bit ALU opcode consumed by the execute-stage ALU.
//  - Decodes a MIPS R/I-type ALU instruction and steers register/immediate/shamt operands onto BusA/BusB.
//  - Registers the result behind a valid/ready handshake, so the ALU sees a stable beat until the consumer accepts it.
// PARAMETERS
//  DATA_W        32       operand width; must be 32
//  REG_ADDR_W    5        destination register index width
//  ILLEGAL_CTRL  4'b0010  ALUCtrl driven with an illegal-instruction beat (ADD)
// PORTS
//  CLK        in   1       clock, rising edge
//  Reset_L    in   1       synchronous active-low reset
//  Flush      in   1       drop held beat and the beat offered this cycle
//  InValid    in   1       Instr/RsData/RtData valid
//  InReady    out  1       stage can accept a beat this cycle
//  Instr      in   32      instruction word
//  RsData     in   32      GPR[rs]
//  RtData     in   32      GPR[rt]
//  OutValid   out  1       issued beat valid
//  OutReady   in   1       execute stage accepts beat
//  ALUCtrl    out  4       AND=0 OR=1 ADD=2 SLL=3 SRL=4 SUB=6 SLT=7 ADDU=8 SUBU=9 XOR=A SLTU=B NOR=C SRA=D LUI=E
//  BusA       out  32      ALU operand A; shift amount for shift ops
//  BusB       out  32      ALU operand B; value being shifted for shift ops
//  DestReg    out  5       writeback index: rd for R-type, rt for I-type
//  WrEn       out  1       writeback enable; 0 when Illegal
//  Illegal    out  1       opcode/funct not in the decode table
// BEHAVIOUR
//  Reset (Reset_L=0 at edge):
//  - All outputs 0: OutValid=0, ALUCtrl=0, BusA=0, BusB=0, DestReg=0, WrEn=0, Illegal=0.
//  - InReady=1 in the first cycle after reset is released. Reset mid-stall discards the held beat.
//  Handshake:
//  - Transfer in on InValid&InReady; transfer out on OutValid&OutReady.
//  - InReady = !OutValid | OutReady (combinational).
//  - Accepted beat appears on the outputs with 1-cycle latency.
//  - While OutValid=1 and OutReady=0, all outputs are held bit-stable.
//  - Simultaneous out-transfer and in-transfer: the new beat replaces the old one; back-to-back throughput is 1/cycle.
//  Flush:
//  - OutValid=0 next cycle; the input beat in the same cycle is not captured.
//  - Flush has priority over capture; reset has priority over Flush.
//  R-type decode (op=0x00, by funct):
//  - Immediate shifts 00/02/03 -> SLL/SRL/SRA: BusA={27'b0,shamt}, BusB=RtData.
//  - Variable shifts 04/06/07 -> SLL/SRL/SRA: BusA={27'b0,RsData[4:0]}, BusB=RtData.
//  - 20/21/22/23 -> ADD/ADDU/SUB/SUBU; 24/25/26/27 -> AND/OR/XOR/NOR; 2A/2B -> SLT/SLTU.
//    For all of these: BusA=RsData, BusB=RtData.
//  - DestReg=rd.
//  I-type decode (BusA=RsData, DestReg=rt):
//  - Sign-extended imm16 on BusB: 08 ADD, 09 ADDU, 0A SLT, 0B SLTU.
//  - Zero-extended imm16 on BusB: 0C AND, 0D OR, 0E XOR.
//  - 0F LUI: BusA=0, BusB={16'b0,imm16}; the ALU performs the <<16.
//  Illegal beat:
//  - Any other op/funct: Illegal=1, WrEn=0, ALUCtrl=ILLEGAL_CTRL, BusA=BusB=0.
//  - The beat is still issued so the downstream stage sees the exception in order.
//  Writeback index 0:
//  - DestReg=0 is issued with WrEn=1; register $0 protection belongs to the register file.
// CONFIGURATION
//  ALU_ISSUE_SKID_EN defined:
//  - Adds a 1-entry skid buffer; InReady becomes a registered signal, equal to "skid empty".
//  - A beat accepted while the output is stalled lands in the skid and moves to the output when OutReady=1.
//  - Ordering preserved; throughput stays 1/cycle.
//  - Flush clears both the output register and the skid.
//  ALU_ISSUE_SKID_EN undefined:
//  - Combinational InReady as above; no skid storage.
// TESTING
//  T1 Instr=0x00221820 (add $3,$1,$2), Rs=5, Rt=7 -> next cycle: OutValid=1, ALUCtrl=2, BusA=5, BusB=7, DestReg=3, WrEn=1.
//  T2 Instr=0x000220C0 (sll $4,$2,3), Rt=1 -> ALUCtrl=3, BusA=3, BusB=1, DestReg=4.
//  T3 Instr=0x2025FFFF (addi) -> ALUCtrl=2, BusB=0xFFFFFFFF, DestReg=5.
//     Instr=0x3425FFFF (ori) -> ALUCtrl=1, BusB=0x0000FFFF.
//     Instr=0x3C061234 (lui) -> ALUCtrl=E, BusA=0, BusB=0x00001234, DestReg=6.
//  T4 Two beats offered, OutReady=0 for 3 cycles:
//     - Beat 1 held stable; InReady=0 (no skid) or beat 2 in skid (skid).
//     - OutReady=1 -> beat 1, then beat 2, no loss or duplication.
//  T5 Flush=1 while OutValid=1 and InValid=1 -> OutValid=0 next cycle; the offered beat never appears.
//     Reset_L=0 during a stall -> all outputs 0.
//  T6 Instr=0x8C220000 (lw) -> Illegal=1, WrEn=0, ALUCtrl=2, BusA=BusB=0, OutValid=1.
//     Instr=0x00000005 (funct 05) -> Illegal=1.

Source files
------------

// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Bundles the handshake and data signals between the ID/EX issue register,
// its producer (decode side) and its consumer (execute-stage ALU).
//
//   Producer -> stage : Flush, InValid, Instr, RsData, RtData
//   Stage -> producer : InReady
//   Stage -> consumer : OutValid, ALUCtrl, BusA, BusB, DestReg, WrEn, Illegal
//   Consumer -> stage : OutReady
//
// Modports
//   master : environment side (drives producer inputs and OutReady)
//   slave  : issue-stage side
// ---------------------------------------------------------------------------
interface alu_issue_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  Flush;
   logic                  InValid;
   logic                  InReady;
   logic [DATA_W-1:0]     Instr;
   logic [DATA_W-1:0]     RsData;
   logic [DATA_W-1:0]     RtData;
   logic                  OutValid;
   logic                  OutReady;
   logic [3:0]            ALUCtrl;
   logic [DATA_W-1:0]     BusA;
   logic [DATA_W-1:0]     BusB;
   logic [REG_ADDR_W-1:0] DestReg;
   logic                  WrEn;
   logic                  Illegal;

   modport master (
      output Flush, InValid, Instr, RsData, RtData, OutReady,
      input  InReady, OutValid, ALUCtrl, BusA, BusB, DestReg, WrEn, Illegal
   );

   modport slave (
      input  Flush, InValid, Instr, RsData, RtData, OutReady,
      output InReady, OutValid, ALUCtrl, BusA, BusB, DestReg, WrEn, Illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX issue register. Decodes a MIPS R/I-type ALU instruction into a 4-bit
// ALU opcode, steers register / immediate / shamt operands onto BusA/BusB and
// holds the result behind a valid/ready handshake.
//
// Ports
//   CLK      : clock, rising edge
//   Reset_L  : synchronous active-low reset
//   io       : alu_issue_if.slave (handshake, instruction, operands, results)
//
// Configuration
//   ALU_ISSUE_SKID_EN : when defined, adds a 1-entry skid buffer and InReady
//                       becomes registered ("skid empty"). When undefined,
//                       InReady = !OutValid | OutReady, no skid storage.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int         DATA_W       = 32,
   parameter int         REG_ADDR_W   = 5,
   parameter logic [3:0] ILLEGAL_CTRL = 4'b0010
) (
   input  logic       CLK,
   input  logic       Reset_L,
   alu_issue_if.slave io
);

   localparam logic [3:0] CTRL_AND  = 4'h0;
   localparam logic [3:0] CTRL_OR   = 4'h1;
   localparam logic [3:0] CTRL_ADD  = 4'h2;
   localparam logic [3:0] CTRL_SLL  = 4'h3;
   localparam logic [3:0] CTRL_SRL  = 4'h4;
   localparam logic [3:0] CTRL_SUB  = 4'h6;
   localparam logic [3:0] CTRL_SLT  = 4'h7;
   localparam logic [3:0] CTRL_ADDU = 4'h8;
   localparam logic [3:0] CTRL_SUBU = 4'h9;
   localparam logic [3:0] CTRL_XOR  = 4'hA;
   localparam logic [3:0] CTRL_SLTU = 4'hB;
   localparam logic [3:0] CTRL_NOR  = 4'hC;
   localparam logic [3:0] CTRL_SRA  = 4'hD;
   localparam logic [3:0] CTRL_LUI  = 4'hE;

   typedef struct packed {
      logic [3:0]            ctrl;
      logic [DATA_W-1:0]     bus_a;
      logic [DATA_W-1:0]     bus_b;
      logic [REG_ADDR_W-1:0] dest;
      logic                  wr_en;
      logic                  illegal;
   } beat_t;

   // Builds a decodable beat; writeback is always enabled, $0 is the regfile's problem.
   function automatic beat_t legal_beat(input logic [3:0]            ctrl,
                                        input logic [DATA_W-1:0]     a,
                                        input logic [DATA_W-1:0]     b,
                                        input logic [REG_ADDR_W-1:0] dest);
      beat_t bt;
      bt.ctrl    = ctrl;
      bt.bus_a   = a;
      bt.bus_b   = b;
      bt.dest    = dest;
      bt.wr_en   = 1'b1;
      bt.illegal = 1'b0;
      return bt;
   endfunction

   // Illegal beats still flow downstream so the exception stays in program order.
   function automatic beat_t illegal_beat();
      beat_t bt;
      bt.ctrl    = ILLEGAL_CTRL;
      bt.bus_a   = '0;
      bt.bus_b   = '0;
      bt.dest    = '0;
      bt.wr_en   = 1'b0;
      bt.illegal = 1'b1;
      return bt;
   endfunction

   // Instruction fields and pre-extended operands
   logic [5:0]            op_s;
   logic [5:0]            funct_s;
   logic [REG_ADDR_W-1:0] rd_s;
   logic [REG_ADDR_W-1:0] rt_idx_s;
   logic [DATA_W-1:0]     shamt_ext_s;
   logic [DATA_W-1:0]     rs_shamt_s;
   logic [DATA_W-1:0]     imm_sext_s;
   logic [DATA_W-1:0]     imm_zext_s;
   logic                  unused_rs_field_s;

   assign op_s        = io.Instr[31:26];
   assign funct_s     = io.Instr[5:0];
   assign rd_s        = io.Instr[15:11];
   assign rt_idx_s    = io.Instr[20:16];
   assign shamt_ext_s = {{(DATA_W-5){1'b0}}, io.Instr[10:6]};
   assign rs_shamt_s  = {{(DATA_W-5){1'b0}}, io.RsData[4:0]};
   assign imm_sext_s  = {{(DATA_W-16){io.Instr[15]}}, io.Instr[15:0]};
   assign imm_zext_s  = {{(DATA_W-16){1'b0}}, io.Instr[15:0]};
   // The rs index is resolved upstream; RsData already carries GPR[rs].
   assign unused_rs_field_s = &{1'b0, io.Instr[25:21]};

   beat_t dec_beat_s;

   // Instruction decode: opcode/funct -> ALU control and operand steering
   always_comb begin
      dec_beat_s = illegal_beat();
      case (op_s)
         6'h00: begin
            case (funct_s)
               6'h00:   dec_beat_s = legal_beat(CTRL_SLL,  shamt_ext_s, io.RtData, rd_s);
               6'h02:   dec_beat_s = legal_beat(CTRL_SRL,  shamt_ext_s, io.RtData, rd_s);
               6'h03:   dec_beat_s = legal_beat(CTRL_SRA,  shamt_ext_s, io.RtData, rd_s);
               6'h04:   dec_beat_s = legal_beat(CTRL_SLL,  rs_shamt_s,  io.RtData, rd_s);
               6'h06:   dec_beat_s = legal_beat(CTRL_SRL,  rs_shamt_s,  io.RtData, rd_s);
               6'h07:   dec_beat_s = legal_beat(CTRL_SRA,  rs_shamt_s,  io.RtData, rd_s);
               6'h20:   dec_beat_s = legal_beat(CTRL_ADD,  io.RsData,   io.RtData, rd_s);
               6'h21:   dec_beat_s = legal_beat(CTRL_ADDU, io.RsData,   io.RtData, rd_s);
               6'h22:   dec_beat_s = legal_beat(CTRL_SUB,  io.RsData,   io.RtData, rd_s);
               6'h23:   dec_beat_s = legal_beat(CTRL_SUBU, io.RsData,   io.RtData, rd_s);
               6'h24:   dec_beat_s = legal_beat(CTRL_AND,  io.RsData,   io.RtData, rd_s);
               6'h25:   dec_beat_s = legal_beat(CTRL_OR,   io.RsData,   io.RtData, rd_s);
               6'h26:   dec_beat_s = legal_beat(CTRL_XOR,  io.RsData,   io.RtData, rd_s);
               6'h27:   dec_beat_s = legal_beat(CTRL_NOR,  io.RsData,   io.RtData, rd_s);
               6'h2A:   dec_beat_s = legal_beat(CTRL_SLT,  io.RsData,   io.RtData, rd_s);
               6'h2B:   dec_beat_s = legal_beat(CTRL_SLTU, io.RsData,   io.RtData, rd_s);
               default: dec_beat_s = illegal_beat();
            endcase
         end
         6'h08:   dec_beat_s = legal_beat(CTRL_ADD,  io.RsData, imm_sext_s, rt_idx_s);
         6'h09:   dec_beat_s = legal_beat(CTRL_ADDU, io.RsData, imm_sext_s, rt_idx_s);
         6'h0A:   dec_beat_s = legal_beat(CTRL_SLT,  io.RsData, imm_sext_s, rt_idx_s);
         6'h0B:   dec_beat_s = legal_beat(CTRL_SLTU, io.RsData, imm_sext_s, rt_idx_s);
         6'h0C:   dec_beat_s = legal_beat(CTRL_AND,  io.RsData, imm_zext_s, rt_idx_s);
         6'h0D:   dec_beat_s = legal_beat(CTRL_OR,   io.RsData, imm_zext_s, rt_idx_s);
         6'h0E:   dec_beat_s = legal_beat(CTRL_XOR,  io.RsData, imm_zext_s, rt_idx_s);
         // LUI: the ALU does the <<16, so only the raw immediate is passed
         6'h0F:   dec_beat_s = legal_beat(CTRL_LUI,  '0,        imm_zext_s, rt_idx_s);
         default: dec_beat_s = illegal_beat();
      endcase
   end

   logic  out_valid_q, out_valid_d;
   beat_t out_beat_q,  out_beat_d;
   logic  in_ready_s;
   logic  accept_s;

   assign accept_s = io.InValid & in_ready_s & ~io.Flush;

`ifdef ALU_ISSUE_SKID_EN
   logic  skid_valid_q, skid_valid_d;
   beat_t skid_beat_q,  skid_beat_d;
   logic  out_free_s;

   // Registered ready: a beat can only be taken while the skid has room for it.
   assign in_ready_s = ~skid_valid_q;
   assign out_free_s = ~out_valid_q | io.OutReady;

   // Next-state for output register and skid entry; skid drains first to keep order
   always_comb begin
      out_valid_d  = out_valid_q;
      out_beat_d   = out_beat_q;
      skid_valid_d = skid_valid_q;
      skid_beat_d  = skid_beat_q;
      if (io.Flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free_s) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_beat_d   = skid_beat_q;
            skid_valid_d = 1'b0;
         end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_beat_d  = dec_beat_s;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept_s) begin
         skid_valid_d = 1'b1;
         skid_beat_d  = dec_beat_s;
      end else begin
         skid_valid_d = skid_valid_q;
      end
   end

   // Skid state register with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         skid_valid_q <= 1'b0;
         skid_beat_q  <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_beat_q  <= skid_beat_d;
      end
   end
`else
   assign in_ready_s = ~out_valid_q | io.OutReady;

   // Next-state for the single output register; Flush beats capture
   always_comb begin
      out_valid_d = out_valid_q;
      out_beat_d  = out_beat_q;
      if (io.Flush) begin
         out_valid_d = 1'b0;
      end else if (accept_s) begin
         out_valid_d = 1'b1;
         out_beat_d  = dec_beat_s;
      end else if (io.OutReady) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end
`endif

   // Output register with synchronous active-low reset clearing every field
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         out_valid_q <= 1'b0;
         out_beat_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_beat_q  <= out_beat_d;
      end
   end

   assign io.InReady  = in_ready_s;
   assign io.OutValid = out_valid_q;
   assign io.ALUCtrl  = out_beat_q.ctrl;
   assign io.BusA     = out_beat_q.bus_a;
   assign io.BusB     = out_beat_q.bus_b;
   assign io.DestReg  = out_beat_q.dest;
   assign io.WrEn     = out_beat_q.wr_en;
   assign io.Illegal  = out_beat_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

   logic CLK = 1'b0;
   logic Reset_L;

   alu_issue_if io_if ();

   alu_issue_stage dut (
      .CLK     (CLK),
      .Reset_L (Reset_L),
      .io      (io_if)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dest;
      logic        wren;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dest;
      logic        wren;
      logic        ill;
   } vec_t;

   int checks = 0;
   int errors = 0;

   exp_t        model_q[$];   // beats held by the stage, oldest first
   logic [31:0] xfer_q[$];    // BusA of every beat handed to the consumer
   bit          after_reset;

`ifdef ALU_ISSUE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference decode written straight from the instruction-set rules
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt);
      exp_t        e;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] sx;
      logic [31:0] zx;
      op = ins[31:26];
      fn = ins[5:0];
      sx = {{16{ins[15]}}, ins[15:0]};
      zx = {16'h0000, ins[15:0]};
      e.ill = 1'b0;
      e.a   = rs;
      e.b   = rt;
      e.ctrl = 4'h0;
      if (op == 6'h00) begin
         e.dest = ins[15:11];
         case (fn)
            6'h00: begin e.ctrl = 4'h3; e.a = {27'h0, ins[10:6]}; end
            6'h02: begin e.ctrl = 4'h4; e.a = {27'h0, ins[10:6]}; end
            6'h03: begin e.ctrl = 4'hD; e.a = {27'h0, ins[10:6]}; end
            6'h04: begin e.ctrl = 4'h3; e.a = rs % 32'd32; end
            6'h06: begin e.ctrl = 4'h4; e.a = rs % 32'd32; end
            6'h07: begin e.ctrl = 4'hD; e.a = rs % 32'd32; end
            6'h20: e.ctrl = 4'h2;
            6'h21: e.ctrl = 4'h8;
            6'h22: e.ctrl = 4'h6;
            6'h23: e.ctrl = 4'h9;
            6'h24: e.ctrl = 4'h0;
            6'h25: e.ctrl = 4'h1;
            6'h26: e.ctrl = 4'hA;
            6'h27: e.ctrl = 4'hC;
            6'h2A: e.ctrl = 4'h7;
            6'h2B: e.ctrl = 4'hB;
            default: e.ill = 1'b1;
         endcase
      end else begin
         e.dest = ins[20:16];
         case (op)
            6'h08: begin e.ctrl = 4'h2; e.b = sx; end
            6'h09: begin e.ctrl = 4'h8; e.b = sx; end
            6'h0A: begin e.ctrl = 4'h7; e.b = sx; end
            6'h0B: begin e.ctrl = 4'hB; e.b = sx; end
            6'h0C: begin e.ctrl = 4'h0; e.b = zx; end
            6'h0D: begin e.ctrl = 4'h1; e.b = zx; end
            6'h0E: begin e.ctrl = 4'hA; e.b = zx; end
            6'h0F: begin e.ctrl = 4'hE; e.a = 32'h0; e.b = zx; end
            default: e.ill = 1'b1;
         endcase
      end
      e.wren = ~e.ill;
      if (e.ill) begin
         e.ctrl = 4'h2;
         e.a    = 32'h0;
         e.b    = 32'h0;
         e.dest = 5'h0;
      end
      return e;
   endfunction

   // DestReg of an illegal beat carries no meaning, so it is zeroed on both sides
   function automatic exp_t dut_beat(input logic ill_mask);
      exp_t d;
      d.ctrl = io_if.ALUCtrl;
      d.a    = io_if.BusA;
      d.b    = io_if.BusB;
      d.dest = ill_mask ? 5'h0 : io_if.DestReg;
      d.wren = io_if.WrEn;
      d.ill  = io_if.Illegal;
      return d;
   endfunction

   // One clock cycle: drive, check ready, clock, advance the model, check outputs
   task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy, input logic fl,
                       input logic rl, output logic acc);
      logic exp_ready;
      io_if.InValid  = iv;
      io_if.Instr    = ins;
      io_if.RsData   = rs;
      io_if.RtData   = rt;
      io_if.OutReady = ordy;
      io_if.Flush    = fl;
      Reset_L        = rl;
`ifdef ALU_ISSUE_SKID_EN
      exp_ready = (model_q.size() < CAP);
`else
      exp_ready = (model_q.size() < CAP) || ordy;
`endif
      #1;
      chk("in_ready", {79'h0, io_if.InReady}, {79'h0, exp_ready});
      if (io_if.OutValid && ordy && rl) xfer_q.push_back(io_if.BusA);
      acc = iv && exp_ready && !fl && rl;
      @(posedge CLK);
      if (!rl) begin
         model_q.delete();
         after_reset = 1'b1;
      end else begin
         after_reset = 1'b0;
         if (fl) begin
            model_q.delete();
         end else begin
            if (ordy && model_q.size() > 0) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(ins, rs, rt));
         end
      end
      #1;
      chk("out_valid", {79'h0, io_if.OutValid}, {79'h0, model_q.size() > 0});
      if (after_reset)
         chk("reset_zero", {5'h0, dut_beat(1'b0)}, 80'h0);
      if (model_q.size() > 0)
         chk("beat", {5'h0, dut_beat(model_q[0].ill)}, {5'h0, model_q[0]});
   endtask

   vec_t        vt[18];
   logic        acc;
   logic [31:0] r_ins, r_rs, r_rt;
   logic        pend;
   logic [5:0]  rfn[16];

   initial begin
      vt[0]  = '{32'h00221820, 32'd5,   32'd7,        4'h2, 32'd5,   32'd7,        5'd3, 1'b1, 1'b0};
      vt[1]  = '{32'h000220C0, 32'd9,   32'd1,        4'h3, 32'd3,   32'd1,        5'd4, 1'b1, 1'b0};
      vt[2]  = '{32'h2025FFFF, 32'd10,  32'd0,        4'h2, 32'd10,  32'hFFFFFFFF, 5'd5, 1'b1, 1'b0};
      vt[3]  = '{32'h3425FFFF, 32'd10,  32'd0,        4'h1, 32'd10,  32'h0000FFFF, 5'd5, 1'b1, 1'b0};
      vt[4]  = '{32'h3C061234, 32'd10,  32'd0,        4'hE, 32'd0,   32'h00001234, 5'd6, 1'b1, 1'b0};
      vt[5]  = '{32'h8C220000, 32'd5,   32'd7,        4'h2, 32'd0,   32'd0,        5'd0, 1'b0, 1'b1};
      vt[6]  = '{32'h00000005, 32'd5,   32'd7,        4'h2, 32'd0,   32'd0,        5'd0, 1'b0, 1'b1};
      vt[7]  = '{32'h00642807, 32'hFF,  32'h80000000, 4'hD, 32'h1F,  32'h80000000, 5'd5, 1'b1, 1'b0};
      vt[8]  = '{32'h00221822, 32'd100, 32'd30,       4'h6, 32'd100, 32'd30,       5'd3, 1'b1, 1'b0};
      vt[9]  = '{32'h00221827, 32'd1,   32'd2,        4'hC, 32'd1,   32'd2,        5'd3, 1'b1, 1'b0};
      vt[10] = '{32'h2C278000, 32'd4,   32'd0,        4'hB, 32'd4,   32'hFFFF8000, 5'd7, 1'b1, 1'b0};
      vt[11] = '{32'h30278000, 32'd4,   32'd0,        4'h0, 32'd4,   32'h00008000, 5'd7, 1'b1, 1'b0};
      vt[12] = '{32'h00220020, 32'd1,   32'd2,        4'h2, 32'd1,   32'd2,        5'd0, 1'b1, 1'b0};
      vt[13] = '{32'h000227C2, 32'd0,   32'hAB,       4'h4, 32'd31,  32'hAB,       5'd4, 1'b1, 1'b0};
      vt[14] = '{32'h0022182B, 32'd1,   32'd2,        4'hB, 32'd1,   32'd2,        5'd3, 1'b1, 1'b0};
      vt[15] = '{32'h3825FFFF, 32'd3,   32'd0,        4'hA, 32'd3,   32'h0000FFFF, 5'd5, 1'b1, 1'b0};
      vt[16] = '{32'h2825FFFF, 32'd3,   32'd0,        4'h7, 32'd3,   32'hFFFFFFFF, 5'd5, 1'b1, 1'b0};
      vt[17] = '{32'h00221821, 32'd1,   32'd2,        4'h8, 32'd1,   32'd2,        5'd3, 1'b1, 1'b0};
      rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
              6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

      // Initial reset with unknown state, then confirm every output cleared
      Reset_L        = 1'b0;
      io_if.InValid  = 1'b0;
      io_if.Instr    = 32'h0;
      io_if.RsData   = 32'h0;
      io_if.RtData   = 32'h0;
      io_if.OutReady = 1'b0;
      io_if.Flush    = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_valid", {79'h0, io_if.OutValid}, 80'h0);
      chk("reset_fields", {5'h0, dut_beat(1'b0)}, 80'h0);
      after_reset = 1'b1;

      // First cycle after release: InReady must be 1
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);

      // Decode table, one beat per cycle with the consumer always ready
      foreach (vt[i]) begin
         step(1'b1, vt[i].ins, vt[i].rs, vt[i].rt, 1'b1, 1'b0, 1'b1, acc);
         chk($sformatf("vec%0d", i), {5'h0, dut_beat(vt[i].ill)},
             {5'h0, vt[i].ctrl, vt[i].a, vt[i].b, vt[i].dest, vt[i].wren, vt[i].ill});
      end
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, acc);

      // Stall with two beats offered: no loss, no duplication, order kept
      xfer_q.delete();
      step(1'b1, 32'h00221820, 32'h111, 32'h1, 1'b0, 1'b0, 1'b1, acc);
      pend = 1'b1;
      repeat (3) begin
         step(pend, 32'h00221820, 32'h222, 32'h2, 1'b0, 1'b0, 1'b1, acc);
         if (acc) pend = 1'b0;
      end
      chk("t4_hold", {48'h0, io_if.BusA}, {48'h0, 32'h111});
      repeat (4) begin
         step(pend, 32'h00221820, 32'h222, 32'h2, 1'b1, 1'b0, 1'b1, acc);
         if (acc) pend = 1'b0;
      end
      chk("t4_count", {48'h0, 32'(xfer_q.size())}, 80'd2);
      if (xfer_q.size() == 2)
         chk("t4_order", {16'h0, xfer_q[0], xfer_q[1]}, {16'h0, 32'h111, 32'h222});

      // Flush while a beat is held and another is offered
      step(1'b1, 32'h00221820, 32'h111, 32'h1, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 32'h00221820, 32'h333, 32'h3, 1'b0, 1'b1, 1'b1, acc);
      chk("t5_flush_valid", {79'h0, io_if.OutValid}, 80'h0);
      xfer_q.delete();
      repeat (3) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
      chk("t5_no_ghost", {48'h0, 32'(xfer_q.size())}, 80'd0);

      // Reset in the middle of a stall
      step(1'b1, 32'h00221820, 32'h444, 32'h4, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 32'h00221820, 32'h555, 32'h5, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 32'h00221820, 32'h666, 32'h6, 1'b0, 1'b0, 1'b0, acc);
      chk("t5_reset_valid", {79'h0, io_if.OutValid}, 80'h0);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, acc);

      // Randomized traffic against the queue model
      pend = 1'b0;
      r_ins = 32'h0; r_rs = 32'h0; r_rt = 32'h0;
      for (int n = 0; n < 3000; n++) begin
         logic rl;
         if (!pend) begin
            r_rs = $urandom;
            r_rt = $urandom;
            r_ins = $urandom;
            case ($urandom_range(0, 7))
               0:       ;
               1, 2, 3: r_ins = {6'h00, r_ins[25:6], rfn[$urandom_range(0, 15)]};
               default: r_ins = {3'b001, r_ins[28:0]};
            endcase
            pend = ($urandom_range(0, 3) != 0);
         end
         rl = ($urandom_range(0, 299) != 0);
         step(pend, r_ins, r_rs, r_rt, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 39) == 0), rl, acc);
         if (acc || !rl) pend = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
